alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0 / req1  in  1  requester 0/1 operation request, held high until granted
- a0, b0 / a1, b1  in  8 each  operands, stable while req high
- cmd0 / cmd1  in  2 each  op code: 00 add, 01 sub, 10 or, 11 and
- gnt0 / gnt1  out  1 each  grant, one-cycle pulse, operands captured on that edge
- res_vld  out  1  result valid
- res_id  out  1  owner of result (0/1)
- res_y  out  8  result
- res_c  out  1  carry out
- res_z  out  1  zero flag
- res_ack  in  1  result consumed
- busy  out  1  high in any state except IDLE
- ops0 / ops1  out  16 each  completed-operation counters per requester

Function
REQ-003 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-004 IDLE: if any req is high, the block SHALL assert exactly one gnt combinationally, latch that requester's a, b, cmd and id on the clock edge, and move to EXEC; with no req it stays in IDLE.
REQ-005 Arbitration SHALL be round-robin: one requester requesting wins; both requesting, the winner is the one not granted last. The priority pointer resets to requester 0 and updates only on a grant.
REQ-006 EXEC SHALL present the latched operands to the ALU datapath, register y/c/z/id into res_* on the edge, and move to RESP. EXEC always lasts one cycle.
REQ-007 RESP SHALL hold res_vld=1 and res_* stable until a clock edge with res_ack=1. On that edge: res_vld clears, the owner's ops counter increments (16-bit, wraps 0xFFFF->0x0000), and the FSM moves to IDLE.
REQ-008 res_ack outside RESP SHALL be ignored. gnt SHALL never be asserted outside IDLE.
REQ-009 Minimum issue period SHALL be 3 cycles: grant, exec, ack. A request arriving while busy waits and is not dropped.
REQ-010 ALU semantics:
- add: {c,y}=a+b (9-bit)
- sub: y=a-b mod 256, c=0
- or / and: bitwise, c=0
- z=1 iff y==0x00, for all ops
REQ-011 res_y/res_c/res_z/res_id SHALL keep their last values after ack, until the next EXEC.

Reset
REQ-012 Reset SHALL force: state=IDLE, gnt0=gnt1=0, res_vld=0, res_y=0, res_c=0, res_z=0, res_id=0, busy=0, ops0=ops1=0, priority pointer=requester 0.
REQ-013 Reset in EXEC or RESP SHALL abort the operation: no result is delivered and no counter increments. A requester whose gnt was already issued is not re-granted for that operation.
REQ-014 Reset SHALL take priority over req and res_ack on the same edge.

Structure
REQ-015 A shared package SHALL hold the FSM state encoding (IDLE=0, EXEC=1, RESP=2) and the cmd codes (CMD_ADD=00, CMD_SUB=01, CMD_OR=10, CMD_AND=11).
REQ-016 The block SHALL instantiate exactly one sub-module, the team's combinational alu datapath (ports a, b, cmd, y, z, c), fed from the operand registers.
REQ-017 Registers: FSM state, operand/cmd/id latch, result registers, priority pointer, two counters. No other storage.

Verification
REQ-018 Req0 add, a0=0xF0, b0=0x20, ack on the first RESP cycle -> gnt0 pulse, res_vld 2 cycles after the grant edge, res_y=0x10, res_c=1, res_z=0, res_id=0, ops0=1.
REQ-019 Req1 sub, 0x05-0x05 -> res_y=0x00, res_z=1, res_c=0; sub 0x03-0x05 -> res_y=0xFE, res_c=0, res_z=0.
REQ-020 req0 and req1 held high continuously for 6 operations from reset -> grant order 0,1,0,1,0,1; final ops0=3, ops1=3.
REQ-021 res_ack held low for 10 cycles in RESP -> res_vld and res_* stable throughout, no new gnt, busy=1; ack -> IDLE on the next edge.
REQ-022 Reset pulsed during EXEC -> next cycle all outputs at reset values, counters 0; after reset the next simultaneous request is granted to requester 0.
REQ-023 ops0 preloaded to 0xFFFF via 65535 operations (or force), one more acked operation -> ops0=0x0000.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: FSM state encoding and ALU op codes shared by the alu_arb slice
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {CMD_ADD = 2'b00, CMD_SUB = 2'b01, CMD_OR = 2'b10, CMD_AND = 2'b11} cmd_t;
endpackage

// File: rtl/alu_arb_if.sv
// alu_arb_if: two-requester request/grant bus, result handshake and op counters; master = requesters/consumer, slave = alu_arb
interface alu_arb_if;
  logic req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] cmd0, cmd1;
  logic gnt0, gnt1;
  logic res_vld, res_id, res_c, res_z, res_ack;
  logic [7:0] res_y;
  logic busy;
  logic [15:0] ops0, ops1;
  modport master (
    output req0, req1, a0, b0, a1, b1, cmd0, cmd1, res_ack,
    input gnt0, gnt1, res_vld, res_id, res_y, res_c, res_z, busy, ops0, ops1
  );
  modport slave (
    input req0, req1, a0, b0, a1, b1, cmd0, cmd1, res_ack,
    output gnt0, gnt1, res_vld, res_id, res_y, res_c, res_z, busy, ops0, ops1
  );
endinterface

// File: rtl/alu_arb_alu.sv
// alu_arb_alu: combinational 8-bit datapath; a,b,cmd in; y result, c carry (add only), z zero flag out
module alu_arb_alu
  import alu_arb_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  cmd_t       cmd,
  output logic [7:0] y,
  output logic       c,
  output logic       z
);
  logic [8:0] s;
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    y = cmd == CMD_ADD ? s[7:0] : cmd == CMD_SUB ? a - b : cmd == CMD_OR ? a | b : a & b;
    c = (cmd == CMD_ADD) & s[8];
    z = y == 8'h00;
  end
endmodule

// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one ALU between two requesters; ports clk, reset (sync, active-high), bus (alu_arb_if.slave)
module alu_arb
  import alu_arb_pkg::*;
(
  input logic   clk,
  input logic   reset,
  alu_arb_if.slave bus
);
  state_t state, state_nx;
  logic [7:0] a_q, b_q, res_y, y;
  cmd_t cmd_q;
  logic id_q, ptr, res_id, res_c, res_z, c, z;
  logic idle, any, pick, gnt;
  logic [15:0] ops0, ops1;
  alu_arb_alu u_alu (.a(a_q), .b(b_q), .cmd(cmd_q), .y(y), .c(c), .z(z));
  // ptr names the requester that wins a tie; it flips away from whoever was just granted
  always_comb begin
    idle = state == IDLE;
    any = bus.req0 | bus.req1;
    pick = bus.req0 & bus.req1 ? ptr : bus.req1;
    gnt = idle & any;
    state_nx = idle ? (any ? EXEC : IDLE) : state == EXEC ? RESP : bus.res_ack ? IDLE : RESP;
    bus.gnt0 = gnt & ~pick;
    bus.gnt1 = gnt & pick;
    bus.busy = ~idle;
    bus.res_vld = state == RESP;
    bus.res_y = res_y;
    bus.res_id = res_id;
    bus.res_c = res_c;
    bus.res_z = res_z;
    bus.ops0 = ops0;
    bus.ops1 = ops1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      cmd_q <= CMD_ADD;
      id_q <= 1'b0;
      res_y <= '0;
      res_id <= 1'b0;
      res_c <= 1'b0;
      res_z <= 1'b0;
      ops0 <= '0;
      ops1 <= '0;
    end else begin
      state <= state_nx;
      if (gnt) begin
        a_q <= pick ? bus.a1 : bus.a0;
        b_q <= pick ? bus.b1 : bus.b0;
        cmd_q <= cmd_t'(pick ? bus.cmd1 : bus.cmd0);
        id_q <= pick;
        ptr <= ~pick;
      end
      if (state == EXEC) begin
        res_y <= y;
        res_id <= id_q;
        res_c <= c;
        res_z <= z;
      end
      if (state == RESP && bus.res_ack) begin
        if (res_id) ops1 <= ops1 + 16'd1;
        else ops0 <= ops0 + 16'd1;
      end
    end
  end
endmodule
